// File: rtl/park_pkg.sv
// ============================================================================
//  Module      : park_pkg
//  Description : Shared definitions for the parking system (entry allocator
//                and exit controller): default sizes, FSM encoding and the
//                free-slot popcount helper.
//  Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

package park_pkg;

    localparam int SLOTS  = 8;
    localparam int SLOT_W = 3;
    localparam int TIME_W = 8;

    typedef enum logic [1:0] {
        S_IDLE  = 2'd0,
        S_CHECK = 2'd1,
        S_OPEN  = 2'd2
    } park_state_t;

    // Number of free (zero) bits in an occupancy bitmap.
    function automatic logic [SLOT_W:0] free_slots(input logic [SLOTS-1:0] map);
        logic [SLOT_W:0] n;
        n = '0;
        for (int i = 0; i < SLOTS; i++) begin
            n = n + (SLOT_W+1)'(~map[i]);
        end
        return n;
    endfunction

endpackage

`default_nettype wire

// File: rtl/exit_park_gate_timer.sv
// ============================================================================
//  Module      : gate_timer
//  Description : Exit gate timer. A load arms a down-counter; the gate output
//                is registered so it rises one edge after the load and stays
//                high for exactly GATE_CYCLES cycles. o_done flags the last
//                counting cycle so the controller can return to IDLE.
//  Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

module gate_timer
    import park_pkg::*;
#(
    parameter int GATE_CYCLES = 4
)(
    input  logic clk,
    input  logic rst,
    input  logic i_load,
    output logic o_gate_open,
    output logic o_done
);

    localparam int CNT_W = $clog2(GATE_CYCLES + 1);

    logic [CNT_W-1:0] r_cnt;
    logic             r_gate;

    // Down-counter plus registered gate drive (gate high while count was non-zero)
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_cnt  <= '0;
            r_gate <= 1'b0;
        end else begin
            r_gate <= (r_cnt != '0);
            if (i_load) begin
                r_cnt <= CNT_W'(GATE_CYCLES);
            end else if (r_cnt != '0) begin
                r_cnt <= r_cnt - 1'b1;
            end
        end
    end

    assign o_gate_open = r_gate;
    assign o_done      = (r_cnt == CNT_W'(1));

endmodule

`default_nettype wire

// File: rtl/exit_park.sv
// ============================================================================
//  Module      : exit_park
//  Description : Exit-side parking controller. Owns the occupancy bitmap
//                (set by the entry side, cleared here), validates exit
//                requests, frees the slot and sequences the exit gate.
//                Optional feature macro: EXIT_FEE_EN (per-slot dwell counters
//                and the o_exit_fee output).
//  Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

module exit_park
    import park_pkg::*;
#(
    parameter int SLOTS       = park_pkg::SLOTS,
    parameter int SLOT_W      = park_pkg::SLOT_W,
    parameter int GATE_CYCLES = 4
`ifdef EXIT_FEE_EN
    ,
    parameter int TIME_W      = park_pkg::TIME_W
`endif
)(
    input  logic              clk,
    input  logic              rst,
    input  logic              i_exit,
    input  logic [SLOT_W-1:0] i_park_number,
    input  logic              i_occupy_valid,
    input  logic [SLOT_W-1:0] i_occupy_slot,
    output logic [SLOTS-1:0]  o_parking_capacity,
    output logic [SLOT_W:0]   o_free_count,
    output logic              o_busy,
    output logic              o_exit_ack,
    output logic              o_exit_err,
    output logic              o_gate_open
`ifdef EXIT_FEE_EN
    ,
    output logic [TIME_W-1:0] o_exit_fee
`endif
);

    localparam logic [SLOT_W:0] c_slots = (SLOT_W+1)'(SLOTS);

    park_state_t       r_state;
    park_state_t       w_next;
    logic [SLOT_W-1:0] r_slot;
    logic [SLOTS-1:0]  r_cap;
    logic [SLOTS-1:0]  w_cap_next;
    logic              r_ack;
    logic              r_err;
    logic              w_accept;
    logic              w_reject;
    logic              w_gate_done;
    logic              w_slot_occ;
    logic              w_occ_ok;

    // An index beyond SLOTS never names an occupied slot, so exit rejects it
    // and occupy ignores it.
    assign w_slot_occ = ({1'b0, r_slot} < c_slots) ? r_cap[r_slot] : 1'b0;
    assign w_occ_ok   = i_occupy_valid && ({1'b0, i_occupy_slot} < c_slots)
                        && !r_cap[i_occupy_slot];

    // FSM state register
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_state <= S_IDLE;
        end else begin
            r_state <= w_next;
        end
    end

    // FSM next state and accept/reject decision
    always_comb begin
        w_next   = r_state;
        w_accept = 1'b0;
        w_reject = 1'b0;
        case (r_state)
            S_IDLE: begin
                if (i_exit) begin
                    w_next = S_CHECK;
                end
            end
            S_CHECK: begin
                if (w_slot_occ) begin
                    w_accept = 1'b1;
                    w_next   = S_OPEN;
                end else begin
                    w_reject = 1'b1;
                    w_next   = S_IDLE;
                end
            end
            S_OPEN: begin
                if (w_gate_done) begin
                    w_next = S_IDLE;
                end
            end
            default: w_next = S_IDLE;
        endcase
    end

    // Slot latch: captures the request only when it is accepted in IDLE
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_slot <= '0;
        end else if ((r_state == S_IDLE) && i_exit) begin
            r_slot <= i_park_number;
        end
    end

    // Bitmap update: occupy sets only a free bit, so on a same-slot
    // collision the clear is the only effect and the bit ends at 0
    always_comb begin
        w_cap_next = r_cap;
        if (w_occ_ok) begin
            w_cap_next[i_occupy_slot] = 1'b1;
        end
        if (w_accept) begin
            w_cap_next[r_slot] = 1'b0;
        end
    end

    // Bitmap and one-cycle result pulses
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_cap <= '0;
            r_ack <= 1'b0;
            r_err <= 1'b0;
        end else begin
            r_cap <= w_cap_next;
            r_ack <= w_accept;
            r_err <= w_reject;
        end
    end

    gate_timer #(
        .GATE_CYCLES (GATE_CYCLES)
    ) u_gate_timer (
        .clk         (clk),
        .rst         (rst),
        .i_load      (w_accept),
        .o_gate_open (o_gate_open),
        .o_done      (w_gate_done)
    );

`ifdef EXIT_FEE_EN
    logic [TIME_W-1:0] r_dwell [SLOTS];
    logic [TIME_W-1:0] r_fee;
    logic [TIME_W-1:0] w_dwell_sel;
    logic [TIME_W-1:0] w_fee_val;

    // Fee includes the cycle ending at the accept edge, so it equals the
    // number of edges from the occupy edge to the CHECK edge.
    assign w_dwell_sel = r_dwell[r_slot];
    assign w_fee_val   = (w_dwell_sel == '1) ? w_dwell_sel : w_dwell_sel + 1'b1;

    // Per-slot saturating dwell counters, restarted when the slot is taken
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            for (int i = 0; i < SLOTS; i++) begin
                r_dwell[i] <= '0;
            end
        end else begin
            for (int i = 0; i < SLOTS; i++) begin
                if (w_occ_ok && (i_occupy_slot == SLOT_W'(i))) begin
                    r_dwell[i] <= '0;
                end else if (r_cap[i] && (r_dwell[i] != '1)) begin
                    r_dwell[i] <= r_dwell[i] + 1'b1;
                end
            end
        end
    end

    // Fee register, held until the next accepted exit
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_fee <= '0;
        end else if (w_accept) begin
            r_fee <= w_fee_val;
        end
    end

    assign o_exit_fee = r_fee;
`endif

    assign o_parking_capacity = r_cap;
    assign o_free_count       = free_slots(r_cap);
    assign o_busy             = (r_state != S_IDLE);
    assign o_exit_ack         = r_ack;
    assign o_exit_err         = r_err;

endmodule

`default_nettype wire

// File: tb/tb_exit_park.sv
// ============================================================================
//  Module      : tb_exit_park
//  Description : Self-checking bench for exit_park. A timeline model (edge
//                numbers of the accepted exit, gate window, busy horizon)
//                predicts every output each cycle; directed scenarios add
//                literal expectations. Define EXIT_FEE_EN to cover the fee.
//  Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

module tb_exit_park;

    localparam int G = 4;

    logic       clk = 1'b0;
    logic       rst;
    logic       exit_req;
    logic [2:0] park_number;
    logic       occupy_valid;
    logic [2:0] occupy_slot;
    logic [7:0] capacity;
    logic [3:0] free_count;
    logic       busy;
    logic       exit_ack;
    logic       exit_err;
    logic       gate_open;
`ifdef EXIT_FEE_EN
    logic [7:0] exit_fee;
`endif

    always #5 clk = ~clk;

    exit_park #(
        .GATE_CYCLES (G)
    ) dut (
        .clk                (clk),
        .rst                (rst),
        .i_exit             (exit_req),
        .i_park_number      (park_number),
        .i_occupy_valid     (occupy_valid),
        .i_occupy_slot      (occupy_slot),
        .o_parking_capacity (capacity),
        .o_free_count       (free_count),
        .o_busy             (busy),
        .o_exit_ack         (exit_ack),
        .o_exit_err         (exit_err),
        .o_gate_open        (gate_open)
`ifdef EXIT_FEE_EN
        ,
        .o_exit_fee         (exit_fee)
`endif
    );

    int total = 0;
    int bad   = 0;
    bit run   = 1'b0;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
        end
    endtask

    // ---------------- timeline model ----------------
    int       cyc = 0;
    bit [7:0] m_cap;
    bit [7:0] m_before;
    int       m_next_ok;     // first edge at which an exit can be taken
    int       m_pend_edge;   // edge an exit was taken (-1 none)
    int       m_pend_slot;
    int       m_ack_edge, m_err_edge, m_g_lo, m_g_hi;
    int       m_occ_edge [8];
    int       m_fee;

    always @(posedge clk or posedge rst) begin
        if (rst) begin
            m_cap       = '0;
            m_next_ok   = 0;
            m_pend_edge = -1;
            m_pend_slot = 0;
            m_ack_edge  = -1;
            m_err_edge  = -1;
            m_g_lo      = 1;
            m_g_hi      = 0;
            m_fee       = 0;
        end else begin
            cyc++;
            m_before = m_cap;
            if (m_pend_edge == cyc - 1) begin
                if (m_before[m_pend_slot]) begin
                    m_cap[m_pend_slot] = 1'b0;
                    m_ack_edge = cyc;
                    m_g_lo     = cyc + 1;
                    m_g_hi     = cyc + G;
                    m_next_ok  = cyc + 1 + G;
                    m_fee      = (cyc - m_occ_edge[m_pend_slot] > 255) ? 255
                                 : cyc - m_occ_edge[m_pend_slot];
                end else begin
                    m_err_edge = cyc;
                end
                m_pend_edge = -1;
            end
            if (occupy_valid && !m_before[occupy_slot]) begin
                m_cap[occupy_slot]      = 1'b1;
                m_occ_edge[occupy_slot] = cyc;
            end
            if (exit_req && (cyc >= m_next_ok)) begin
                m_pend_edge = cyc;
                m_pend_slot = int'(park_number);
                m_next_ok   = cyc + 2;
            end
        end
    end

    function automatic int zeros(input bit [7:0] v);
        int n = 0;
        for (int i = 0; i < 8; i++) if (!v[i]) n++;
        return n;
    endfunction

    int ack_cnt = 0, err_cnt = 0, gate_cnt = 0;

    // Per-cycle comparison against the model
    always @(negedge clk) begin
        if (!rst && run) begin
            chk("capacity",   32'(capacity),   32'(m_cap));
            chk("free_count", 32'(free_count), 32'(zeros(m_cap)));
            chk("busy",       32'(busy),       32'(cyc + 1 < m_next_ok));
            chk("exit_ack",   32'(exit_ack),   32'(cyc == m_ack_edge));
            chk("exit_err",   32'(exit_err),   32'(cyc == m_err_edge));
            chk("gate_open",  32'(gate_open),  32'((cyc >= m_g_lo) && (cyc <= m_g_hi)));
`ifdef EXIT_FEE_EN
            chk("exit_fee",   32'(exit_fee),   32'(m_fee));
`endif
            if (exit_ack)  ack_cnt++;
            if (exit_err)  err_cnt++;
            if (gate_open) gate_cnt++;
        end
    end

    task automatic do_exit(input logic [2:0] s);
        @(negedge clk);
        exit_req    = 1'b1;
        park_number = s;
        @(negedge clk);
        exit_req    = 1'b0;
    endtask

    task automatic do_occupy(input logic [2:0] s);
        @(negedge clk);
        occupy_valid = 1'b1;
        occupy_slot  = s;
        @(negedge clk);
        occupy_valid = 1'b0;
    endtask

    int a0, e0, g0;

    initial begin
        rst          = 1'b1;
        exit_req     = 1'b0;
        park_number  = '0;
        occupy_valid = 1'b0;
        occupy_slot  = '0;
        repeat (2) @(posedge clk);
        #1;
        chk("reset capacity", 32'(capacity),   32'h0);
        chk("reset free",     32'(free_count), 32'd8);
        chk("reset busy",     32'(busy),       32'd0);
        chk("reset gate",     32'(gate_open),  32'd0);
        chk("reset ack/err",  32'({exit_ack, exit_err}), 32'd0);
        @(posedge clk);
        #2 rst = 1'b0;
        run = 1'b1;

        // Occupancy load: slots 0, 2, 4 on consecutive cycles
        @(negedge clk); occupy_valid = 1'b1; occupy_slot = 3'd0;
        @(negedge clk); occupy_slot = 3'd2;
        @(negedge clk); occupy_slot = 3'd4;
        @(negedge clk); occupy_valid = 1'b0;
        chk("load capacity", 32'(capacity),   32'h15);
        chk("load free",     32'(free_count), 32'd5);

        // Valid exit of slot 2
        a0 = ack_cnt; e0 = err_cnt; g0 = gate_cnt;
        do_exit(3'd2);
        repeat (8) @(negedge clk);
        chk("valid capacity", 32'(capacity),   32'h11);
        chk("valid free",     32'(free_count), 32'd6);
        chk("valid ack pulses", 32'(ack_cnt - a0),  32'd1);
        chk("valid gate cycles", 32'(gate_cnt - g0), 32'd4);
        chk("valid err pulses", 32'(err_cnt - e0),  32'd0);

        // Invalid exit of free slot 1
        a0 = ack_cnt; e0 = err_cnt; g0 = gate_cnt;
        do_exit(3'd1);
        repeat (4) @(negedge clk);
        chk("invalid capacity",  32'(capacity),       32'h11);
        chk("invalid err pulses", 32'(err_cnt - e0),  32'd1);
        chk("invalid gate cycles", 32'(gate_cnt - g0), 32'd0);
        chk("invalid ack pulses", 32'(ack_cnt - a0),  32'd0);

        // Collision: same slot (4) occupied in its CHECK cycle -> clear wins
        a0 = ack_cnt; e0 = err_cnt; g0 = gate_cnt;
        @(negedge clk); exit_req = 1'b1; park_number = 3'd4;
        @(negedge clk); exit_req = 1'b0; occupy_valid = 1'b1; occupy_slot = 3'd4;
        @(negedge clk); occupy_valid = 1'b0;
        repeat (8) @(negedge clk);
        chk("collision same slot", 32'(capacity), 32'h01);
        // Different slot (7) in CHECK of slot 0, then an exit during OPEN
        @(negedge clk); exit_req = 1'b1; park_number = 3'd0;
        @(negedge clk); exit_req = 1'b0; occupy_valid = 1'b1; occupy_slot = 3'd7;
        @(negedge clk); occupy_valid = 1'b0; exit_req = 1'b1; park_number = 3'd7;
        @(negedge clk); exit_req = 1'b0;
        repeat (8) @(negedge clk);
        chk("collision diff slot", 32'(capacity), 32'h80);
        chk("collision ack pulses", 32'(ack_cnt - a0),  32'd2);
        chk("collision gate cycles", 32'(gate_cnt - g0), 32'd8);
        chk("collision err pulses", 32'(err_cnt - e0),  32'd0);

        // Reset during the second OPEN cycle
        do_occupy(3'd1);
        @(negedge clk); exit_req = 1'b1; park_number = 3'd1;
        @(posedge clk);
        @(negedge clk); exit_req = 1'b0;
        @(posedge clk);
        @(posedge clk);
        #1;
        chk("pre-reset gate",     32'(gate_open), 32'd1);
        chk("pre-reset busy",     32'(busy),      32'd1);
        chk("pre-reset capacity", 32'(capacity),  32'h80);
        #1 rst = 1'b1;
        #1;
        chk("mid-gate reset gate",     32'(gate_open),  32'd0);
        chk("mid-gate reset busy",     32'(busy),       32'd0);
        chk("mid-gate reset capacity", 32'(capacity),   32'h0);
        chk("mid-gate reset free",     32'(free_count), 32'd8);
        @(posedge clk);
        #2 rst = 1'b0;
        repeat (2) @(negedge clk);

`ifdef EXIT_FEE_EN
        // Dwell fee: 23 edges from occupy edge to CHECK edge
        do_occupy(3'd3);
        repeat (20) @(negedge clk);
        do_exit(3'd3);
        repeat (8) @(negedge clk);
        chk("fee short", 32'(exit_fee), 32'd23);
        // Saturation after a long stay
        do_occupy(3'd5);
        repeat (300) @(negedge clk);
        do_exit(3'd5);
        repeat (8) @(negedge clk);
        chk("fee saturated", 32'(exit_fee), 32'd255);
`endif

        repeat (2) @(negedge clk);
        run = 1'b0;
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule

`default_nettype wire
